// File: rtl/multi_cycle_cpu.sv
// Multi-cycle MIPS-subset core: one shared ALU and a single unified memory port
// for fetch and data, with retire/halt status and a retired-instruction counter.
module multi_cycle_cpu #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   mem_req,
    output logic                   mem_we,
    output logic [31:0]            mem_addr,
    output logic [31:0]            mem_wdata,
    input  logic [31:0]            mem_rdata,
    input  logic                   mem_ready,
    output logic                   retired,
    output logic [COUNT_WIDTH-1:0] instr_count,
    output logic                   halted
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [COUNT_WIDTH-1:0] COUNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_WB_R, S_EXEC_I, S_WB_I, S_MEM_ADDR,
        S_MEM_RD, S_WB_MEM, S_MEM_WR, S_BRANCH, S_JUMP, S_HALT
    } state_e;

    state_e                 state_q, state_d;
    logic [31:0]            pc_q, ir_q, a_q, b_q, alu_q, mdr_q, target_q;
    logic [31:0]            regs_q [32];
    logic [COUNT_WIDTH-1:0] count_q;

    logic [5:0]  opcode_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s, wb_addr_s;
    logic [31:0] imm_s, ea_s, alu_r_s, wb_data_s;
    logic        funct_ok_s, taken_s, req_s, we_s, retire_s, wb_en_s;

    assign opcode_s = ir_q[31:26];
    assign rs_s     = ir_q[25:21];
    assign rt_s     = ir_q[20:16];
    assign rd_s     = ir_q[15:11];
    assign funct_s  = ir_q[5:0];
    assign imm_s    = {{16{ir_q[15]}}, ir_q[15:0]};
    assign ea_s     = a_q + imm_s;
    assign taken_s  = (opcode_s == OP_BEQ) ? (a_q == b_q) : (a_q != b_q);

    // Memory-side outputs; reset gates the request so an in-flight access is abandoned.
    assign mem_req     = req_s & ~reset;
    assign mem_we      = we_s;
    assign mem_addr    = (state_q == S_FETCH) ? pc_q : alu_q;
    assign mem_wdata   = b_q;
    assign retired     = retire_s & ~reset;
    assign halted      = (state_q == S_HALT) & ~reset;
    assign instr_count = count_q;

    // R-type ALU result and funct legality
    always_comb begin
        alu_r_s    = 32'h0000_0000;
        funct_ok_s = 1'b1;
        case (funct_s)
            FN_ADD:  alu_r_s = a_q + b_q;
            FN_SUB:  alu_r_s = a_q - b_q;
            FN_AND:  alu_r_s = a_q & b_q;
            FN_OR:   alu_r_s = a_q | b_q;
            FN_SLT:  alu_r_s = {31'h0000_0000, ($signed(a_q) < $signed(b_q))};
            default: funct_ok_s = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state, memory control, write-back and retire decode
    always_comb begin
        state_d   = state_q;
        req_s     = 1'b0;
        we_s      = 1'b0;
        retire_s  = 1'b0;
        wb_en_s   = 1'b0;
        wb_addr_s = 5'd0;
        wb_data_s = 32'h0000_0000;
        case (state_q)
            S_FETCH: begin
                req_s = 1'b1;
                if (mem_ready) state_d = S_DECODE;
                else           state_d = S_FETCH;
            end
            S_DECODE: begin
                case (opcode_s)
                    OP_RTYPE: begin
                        if (funct_ok_s) state_d = S_EXEC_R;
                        else            state_d = S_HALT;
                    end
                    OP_ADDI:        state_d = S_EXEC_I;
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_BEQ, OP_BNE: state_d = S_BRANCH;
                    OP_J:           state_d = S_JUMP;
                    default:        state_d = S_HALT;
                endcase
            end
            S_EXEC_R: state_d = S_WB_R;
            S_WB_R: begin
                retire_s  = 1'b1;
                wb_en_s   = 1'b1;
                wb_addr_s = rd_s;
                wb_data_s = alu_q;
                state_d   = S_FETCH;
            end
            S_EXEC_I: state_d = S_WB_I;
            S_WB_I: begin
                retire_s  = 1'b1;
                wb_en_s   = 1'b1;
                wb_addr_s = rt_s;
                wb_data_s = alu_q;
                state_d   = S_FETCH;
            end
            S_MEM_ADDR: begin
                if (ea_s[1:0] != 2'b00)     state_d = S_HALT;
                else if (opcode_s == OP_LW) state_d = S_MEM_RD;
                else                        state_d = S_MEM_WR;
            end
            S_MEM_RD: begin
                req_s = 1'b1;
                if (mem_ready) state_d = S_WB_MEM;
                else           state_d = S_MEM_RD;
            end
            S_WB_MEM: begin
                retire_s  = 1'b1;
                wb_en_s   = 1'b1;
                wb_addr_s = rt_s;
                wb_data_s = mdr_q;
                state_d   = S_FETCH;
            end
            S_MEM_WR: begin
                req_s = 1'b1;
                we_s  = 1'b1;
                if (mem_ready) begin
                    retire_s = 1'b1;
                    state_d  = S_FETCH;
                end else begin
                    state_d  = S_MEM_WR;
                end
            end
            S_BRANCH, S_JUMP: begin
                retire_s = 1'b1;
                state_d  = S_FETCH;
            end
            S_HALT:  state_d = S_HALT;
            default: state_d = S_HALT;
        endcase
    end

    // Datapath registers, register file and retire counter
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            ir_q     <= 32'h0000_0000;
            a_q      <= 32'h0000_0000;
            b_q      <= 32'h0000_0000;
            alu_q    <= 32'h0000_0000;
            mdr_q    <= 32'h0000_0000;
            target_q <= 32'h0000_0000;
            count_q  <= '0;
            for (int i = 0; i < 32; i++) regs_q[i] <= 32'h0000_0000;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (mem_ready) begin
                        ir_q <= mem_rdata;
                        pc_q <= pc_q + 32'd4;
                    end
                end
                S_DECODE: begin
                    a_q      <= regs_q[rs_s];
                    b_q      <= regs_q[rt_s];
                    target_q <= pc_q + (imm_s << 2);
                end
                S_EXEC_R:   alu_q <= alu_r_s;
                S_EXEC_I:   alu_q <= ea_s;
                S_MEM_ADDR: alu_q <= ea_s;
                S_MEM_RD: begin
                    if (mem_ready) mdr_q <= mem_rdata;
                end
                S_BRANCH: begin
                    if (taken_s) pc_q <= target_q;
                end
                S_JUMP:  pc_q <= {pc_q[31:28], ir_q[25:0], 2'b00};
                default: ;
            endcase
            // $0 is never written, so it always reads as zero
            if (wb_en_s && (wb_addr_s != 5'd0)) regs_q[wb_addr_s] <= wb_data_s;
            if (retire_s) count_q <= count_q + COUNT_ONE;
        end
    end
endmodule

// File: doc/multi_cycle_cpu.md
# multi_cycle_cpu

Multi-cycle MIPS-subset core: one instruction executes over several state-machine cycles, sharing one ALU and a single unified memory port for instruction fetch and data access. Memory has variable latency behind a req/ready handshake. The core adds retire/halt status and an instruction counter, and sits between a testbench or system bus and a single-port instruction+data memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset.
- COUNT_WIDTH, 16, width of the retired-instruction counter.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- mem_req  out  1  memory transaction request.
- mem_we  out  1  1 = write, 0 = read; valid only when mem_req = 1.
- mem_addr  out  32  byte address, word aligned.
- mem_wdata  out  32  store data.
- mem_rdata  in  32  read data; valid in a cycle where mem_req & mem_ready & !mem_we.
- mem_ready  in  1  transaction completes on the rising edge where mem_req & mem_ready.
- retired  out  1  one-cycle pulse: an instruction completed this cycle.
- instr_count  out  COUNT_WIDTH  number of retired instructions, wraps modulo 2^COUNT_WIDTH.
- halted  out  1  core is in HALT.

## Operation
- Supported opcodes:
  - 0x00 R-type, funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed).
  - 0x08 addi, 0x23 lw, 0x2B sw, 0x04 beq, 0x05 bne, 0x02 j.
- Any other opcode or funct goes to HALT.
- Register file: 32×32. $0 reads 0 and ignores writes. All registers clear on reset.
- Arithmetic is modulo 2^32, with no overflow trap. Immediates are sign-extended 16→32.
- Branch target = PC+4 + (sext(imm) << 2).
- Jump target = {PC+4[31:28], instr[25:0], 2'b00}.
- States and transitions:
  - FETCH: mem_req=1, mem_we=0, mem_addr=PC. On handshake, latch IR and set PC ← PC+4. Go to DECODE.
  - DECODE: read rs/rt into A/B and compute the branch target.
    - R → EXEC_R
    - addi → EXEC_I
    - lw/sw → MEM_ADDR
    - beq/bne → BRANCH
    - j → JUMP
    - illegal → HALT
  - EXEC_R → WB_R: write rd. WB_R goes to FETCH.
  - EXEC_I → WB_I: write rt. WB_I goes to FETCH.
  - MEM_ADDR: compute A+sext(imm). If addr[1:0] ≠ 0 → HALT. Otherwise lw → MEM_RD, sw → MEM_WR.
  - MEM_RD: mem_req=1, mem_we=0. On handshake, latch mem_rdata → WB_MEM. WB_MEM writes rt, then goes to FETCH.
  - MEM_WR: mem_req=1, mem_we=1, mem_wdata=B. On handshake → FETCH.
  - BRANCH: beq taken if A==B, bne taken if A≠B. If taken, PC ← target. Go to FETCH.
  - JUMP: PC ← jump target. Go to FETCH.
  - HALT: absorbing until reset. mem_req=0, halted=1, no register/PC/counter updates.
- retired pulses, and instr_count increments, on the last cycle of each instruction:
  - WB_R, WB_I, WB_MEM.
  - MEM_WR handshake.
  - BRANCH, JUMP.
- Illegal or halting instructions do not retire.

## Timing
- Reset values: state=FETCH, PC=RESET_PC, all registers 0, instr_count=0, retired=0, halted=0.
- mem_req is forced to 0 while reset is high.
- The first fetch request appears in the first cycle after reset deasserts.
- With zero-wait memory (mem_ready high in the request cycle), cycles per instruction are:
  - beq/bne/j: 3
  - R/addi/sw: 4
  - lw: 5
- Each cycle with mem_req=1 and mem_ready=0 adds one cycle.
- mem_addr, mem_we and mem_wdata are held stable while waiting for mem_ready.
- mem_ready may be combinational; it is ignored when mem_req=0.
- Reset mid-transaction abandons the access. mem_req drops in the same cycle reset is high, and the core restarts at RESET_PC.
- instr_count wraps from all-ones to 0 with no flag.

## Test plan
- Reset 2 cycles. Program: addi $1,$0,5; addi $2,$1,-3; add $3,$1,$2; sw $3,0x100($0). Required: a write with addr 0x100, data 7; instr_count=4 after 16 cycles.
- Same program with mem_ready delayed 3 cycles on every access. Required: the first addi retires on cycle 7; mem_addr stays stable through each wait.
- Loop: addi $1,$0,3; loop: addi $1,$1,-1; bne $1,$0,loop; beq $0,$0,+0. Required: the bne is taken twice then falls through; the beq is taken to the next PC; $1=0.
- lw $2,2($0). Required: halted=1 after MEM_ADDR, no data request, mem_req stays 0, instr_count frozen. An opcode 0x3F likewise halts from DECODE.
- Assert reset during a lw read wait. Required: mem_req=0 in that cycle, PC=RESET_PC, and the next fetch goes to addr 0.
- addi $0,$0,9; sw $0,0x40($0). Required: a write to addr 0x40 with data 0.
